// File: rtl/caliptra_prim_onehot_rr_grant.sv
// Registered round-robin arbiter producing a (onehot, index, valid) grant triple.
// Optional registered self-check of the triple: define CALIPTRA_ONEHOT_GNT_SELFCHECK_EN.
module caliptra_prim_onehot_rr_grant #(
  parameter int AddrWidth     = 5,
  parameter int OneHotWidth   = 2**AddrWidth,
  parameter int TimeoutCycles = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [OneHotWidth-1:0] req_i,
  input  logic                   ack_i,
  output logic [OneHotWidth-1:0] gnt_oh_o,
  output logic [AddrWidth-1:0]   gnt_idx_o,
  output logic                   gnt_valid_o,
  output logic                   timeout_o,
  output logic                   err_o
);

  localparam int CntW   = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam int ToLast = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e                 state_q;
  logic [AddrWidth-1:0]   ptr_q;
  logic [CntW-1:0]        cnt_q;
  logic [OneHotWidth-1:0] gnt_oh_q;
  logic [AddrWidth-1:0]   gnt_idx_q;
  logic                   gnt_valid_q;
  logic                   timeout_q;

  // Returns {found, index}: lowest requester at or above start, else lowest below it.
  function automatic logic [AddrWidth:0] pick(input logic [OneHotWidth-1:0] req,
                                              input logic [AddrWidth-1:0]   start);
    logic                 hi_found, lo_found;
    logic [AddrWidth-1:0] hi_idx, lo_idx;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = OneHotWidth - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (AddrWidth'(i) >= start) begin
          hi_found = 1'b1;
          hi_idx   = AddrWidth'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = AddrWidth'(i);
        end
      end
    end
    if (hi_found) return {1'b1, hi_idx};
    return {lo_found, lo_idx};
  endfunction

  logic [AddrWidth-1:0] nxt_ptr;
  logic [AddrWidth:0]   idle_pick, rel_pick;
  logic                 to_hit, release_now;

  always_comb begin
    nxt_ptr     = (gnt_idx_q == AddrWidth'(OneHotWidth - 1)) ? '0
                                                             : gnt_idx_q + AddrWidth'(1);
    idle_pick   = pick(req_i, ptr_q);
    rel_pick    = pick(req_i & ~gnt_oh_q, nxt_ptr);
    to_hit      = (TimeoutCycles > 0) && (cnt_q == CntW'(ToLast));
    release_now = ack_i || to_hit;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; reset is synchronous, so it sits inside the clocked branch.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      gnt_oh_q    <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (idle_pick[AddrWidth]) begin
            gnt_oh_q    <= OneHotWidth'(1) << idle_pick[AddrWidth-1:0];
            gnt_idx_q   <= idle_pick[AddrWidth-1:0];
            gnt_valid_q <= 1'b1;
            state_q     <= GRANT;
          end else begin
            gnt_oh_q    <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
          end
        end
        GRANT: begin
          if (release_now) begin
            ptr_q     <= nxt_ptr;
            timeout_q <= !ack_i;
            cnt_q     <= '0;
            if (rel_pick[AddrWidth]) begin
              gnt_oh_q  <= OneHotWidth'(1) << rel_pick[AddrWidth-1:0];
              gnt_idx_q <= rel_pick[AddrWidth-1:0];
            end else begin
              gnt_oh_q    <= '0;
              gnt_idx_q   <= '0;
              gnt_valid_q <= 1'b0;
              state_q     <= IDLE;
            end
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_oh_o    = gnt_oh_q;
  assign gnt_idx_o   = gnt_idx_q;
  assign gnt_valid_o = gnt_valid_q;
  assign timeout_o   = timeout_q;

`ifdef CALIPTRA_ONEHOT_GNT_SELFCHECK_EN
  logic err_q, idx_bit, chk_bad;

  always_comb begin
    idx_bit = 1'b0;
    for (int i = 0; i < OneHotWidth; i++) begin
      if (AddrWidth'(i) == gnt_idx_q) idx_bit = gnt_oh_q[i];
    end
    chk_bad = ((gnt_oh_q & (gnt_oh_q - OneHotWidth'(1))) != '0) ||
              ((|gnt_oh_q) != gnt_valid_q) ||
              (idx_bit != gnt_valid_q);
  end

  // Sticky until reset so a transient fault is never lost.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)      err_q <= 1'b0;
    else if (chk_bad) err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
